// File: rtl/warp_dispatcher.sv
// rtl/warp_dispatcher.sv - kernel FIFO plus one-warp-at-a-time launch/retire sequencer
// Optional run watchdog enabled by defining WARP_WATCHDOG_EN.
package warp_dispatcher_pkg;
  typedef struct packed {
    logic [3:0]  warp_id;
    logic [31:0] start_pc;
    logic [15:0] thread_count;
  } kernel_t;
endpackage

module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         submit_valid,
  output logic                         submit_ready,
  input  kernel_t                      submit_kernel,
  input  logic                         flush,
  output kernel_t                      core_kernel,
  output logic                         core_rst,
  input  logic                         core_finished,
  input  logic [3:0]                   core_finished_warp_id,
  output logic                         done_valid,
  output logic [3:0]                   done_warp_id,
  output logic                         done_timeout,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic [15:0]                  warps_retired
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RST_CYCLES + 1);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || RST_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("warp_dispatcher: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, RETIRE} state_e;

  state_e        state_q, state_d;
  kernel_t       mem_q [QUEUE_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  kernel_t       kern_q, kern_d;
  logic          core_rst_q, core_rst_d;
  logic          done_valid_q, done_valid_d;
  logic          done_to_q, done_to_d;
  logic          to_pend_q, to_pend_d;
  logic [3:0]    done_id_q, done_id_d;
  logic [15:0]   retired_q, retired_d;
  logic          full, empty, push, pop, match;
`ifdef WARP_WATCHDOG_EN
  logic [15:0]   wd_q, wd_d;
`endif

  always_comb begin
    full         = (cnt_q == CW'(QUEUE_DEPTH));
    empty        = (cnt_q == '0);
    push         = submit_valid && !full && !flush;
    pop          = (state_q == IDLE) && !empty;
    match        = core_finished && (core_finished_warp_id == kern_q.warp_id);
    state_d      = state_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    kern_d       = kern_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_to_d    = done_to_q;
    to_pend_d    = to_pend_q;
    retired_d    = retired_q;
`ifdef WARP_WATCHDOG_EN
    wd_d         = wd_q;
`endif
    // flush beats a same-cycle push, but a same-cycle pop still launches its warp
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    case (state_q)
      IDLE: begin
        if (pop) begin
          kern_d    = mem_q[rd_q];
          to_pend_d = 1'b0;
          if (mem_q[rd_q].thread_count == '0) begin
            state_d = RETIRE;
          end else begin
            state_d = CORE_RST;
            rcnt_d  = '0;
          end
        end
      end
      CORE_RST: begin
        if (rcnt_q == RW'(RST_CYCLES)) begin
          state_d = RUN;
`ifdef WARP_WATCHDOG_EN
          wd_d    = '0;
`endif
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (match) begin
          state_d = RETIRE;
`ifdef WARP_WATCHDOG_EN
        end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d   = RETIRE;
          to_pend_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
`endif
        end
      end
      RETIRE: begin
        state_d      = IDLE;
        done_valid_d = 1'b1;
        done_id_d    = kern_q.warp_id;
        done_to_d    = to_pend_q;
        retired_d    = retired_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    core_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= submit_kernel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      kern_q       <= '0;
      core_rst_q   <= 1'b1;
      done_valid_q <= 1'b0;
      done_id_q    <= 4'hF;
      done_to_q    <= 1'b0;
      to_pend_q    <= 1'b0;
      retired_q    <= '0;
`ifdef WARP_WATCHDOG_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      kern_q       <= kern_d;
      core_rst_q   <= core_rst_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_to_q    <= done_to_d;
      to_pend_q    <= to_pend_d;
      retired_q    <= retired_d;
`ifdef WARP_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign submit_ready  = !full;
  assign core_kernel   = kern_q;
  assign core_rst      = core_rst_q;
  assign done_valid    = done_valid_q;
  assign done_warp_id  = done_id_q;
  assign done_timeout  = done_to_q;
  assign busy          = (state_q != IDLE) || !empty;
  assign queue_count   = cnt_q;
  assign warps_retired = retired_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// tb/tb_warp_dispatcher.sv - directed and random checks of warp_dispatcher against a warp-lifecycle model
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  localparam int DEPTH = 4;
  localparam int RSTC  = 2;
  localparam int NEVER = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       submit_valid = 1'b0;
  logic       submit_ready;
  kernel_t    submit_kernel = '0;
  logic       flush = 1'b0;
  kernel_t    core_kernel;
  logic       core_rst;
  logic       core_finished = 1'b0;
  logic [3:0] core_finished_warp_id = 4'h0;
  logic       done_valid;
  logic [3:0] done_warp_id;
  logic       done_timeout;
  logic       busy;
  logic [2:0] queue_count;
  logic [15:0] warps_retired;

  always #5 clk = ~clk;

  warp_dispatcher #(.QUEUE_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst),
    .submit_valid(submit_valid), .submit_ready(submit_ready), .submit_kernel(submit_kernel),
    .flush(flush), .core_kernel(core_kernel), .core_rst(core_rst),
    .core_finished(core_finished), .core_finished_warp_id(core_finished_warp_id),
    .done_valid(done_valid), .done_warp_id(done_warp_id), .done_timeout(done_timeout),
    .busy(busy), .queue_count(queue_count), .warps_retired(warps_retired)
  );

  int checks = 0;
  int errors = 0;

  // Model: queued descriptors plus the edge numbers at which the active warp was
  // popped, is released into RUN, and enters retirement.
  kernel_t     m_q[$];
  kernel_t     m_act;
  bit          m_have;
  int          m_run, m_ret;
  bit          m_done;
  logic [3:0]  m_done_id;
  logic [15:0] m_retired;
  int          cyc;

  logic [3:0] got[$];
  int         low_cnt;
  int         done_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_act = '0; m_have = 0; m_run = NEVER; m_ret = -1;
    m_done = 0; m_done_id = 4'hF; m_retired = '0;
  endtask

  function automatic bit m_running();
    return m_have && m_ret < 0 && cyc >= m_run;
  endfunction

  task automatic model_step();
    bit acc;
    cyc++;
    acc = submit_valid && (m_q.size() < DEPTH) && !flush;
    m_done = 0;
    if (m_have) begin
      if (m_ret < 0 && cyc > m_run && core_finished && core_finished_warp_id == m_act.warp_id) begin
        m_ret = cyc;
      end else if (m_ret >= 0 && cyc == m_ret + 1) begin
        m_done = 1; m_done_id = m_act.warp_id; m_retired++; m_have = 0;
      end
    end else if (m_q.size() > 0) begin
      m_act  = m_q.pop_front();
      m_have = 1;
      if (m_act.thread_count == 0) begin
        m_ret = cyc; m_run = NEVER;
      end else begin
        m_ret = -1; m_run = cyc + RSTC + 1;
      end
    end
    if (flush) m_q.delete();
    else if (acc) m_q.push_back(submit_kernel);
  endtask

  task automatic check_all();
    chk("core_rst", core_rst, !m_running());
    chk("done_valid", done_valid, m_done);
    chk("done_warp_id", done_warp_id, m_done_id);
    chk("done_timeout", done_timeout, 1'b0);
    chk("busy", busy, m_have || m_q.size() > 0);
    chk("queue_count", queue_count, m_q.size());
    chk("submit_ready", submit_ready, m_q.size() < DEPTH);
    chk("warps_retired", warps_retired, m_retired);
    chk("core_kernel", core_kernel, m_act);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
    if (done_valid === 1'b1) begin
      got.push_back(done_warp_id);
      done_cyc = cyc;
    end
    if (core_rst === 1'b0) low_cnt++;
  endtask

  task automatic push(input logic [3:0] id, input logic [15:0] tc);
    submit_valid = 1'b1;
    submit_kernel.warp_id = id;
    submit_kernel.start_pc = $urandom;
    submit_kernel.thread_count = tc;
    tick();
    submit_valid = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!m_running() && n < 200) begin
      tick();
      n++;
    end
    if (!m_running()) begin
      checks++; errors++;
      $error("FAIL wait_run: observed no RUN after %0d cycles expected RUN", n);
    end
  endtask

  task automatic finish(input logic [3:0] id);
    core_finished = 1'b1;
    core_finished_warp_id = id;
    tick();
    core_finished = 1'b0;
  endtask

  initial begin
    int n;
    int push_cyc;
    model_reset();
    cyc = 0;
    #2 rst = 1'b0;
    #1 check_all();
    tick(); tick();
    rst = 1'b1;
    tick();

    // single warp, 20 RUN cycles
    submit_valid = 1'b1;
    submit_kernel.warp_id = 4'd3; submit_kernel.start_pc = 32'h100; submit_kernel.thread_count = 16'd4;
    tick();
    submit_valid = 1'b0;
    low_cnt = 0;
    got.delete();
    wait_run();
    repeat (19) tick();
    finish(4'd3);
    tick(); tick();
    chk("t1_rst_low_cycles", low_cnt, 20);
    chk("t1_done_count", got.size(), 1);
    chk("t1_done_id", got[0], 4'd3);
    chk("t1_retired", warps_retired, 16'd1);

    // five back-to-back while core stalls
    got.delete();
    for (int i = 0; i < 5; i++) push(4'(i), 16'($urandom_range(1, 50)));
    chk("t2_ready_full", submit_ready, 1'b0);
    chk("t2_count_full", queue_count, 3'd4);
    submit_valid = 1'b1; tick(); tick(); submit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_run();
      repeat ($urandom_range(0, 10)) tick();
      finish(4'(i));
    end
    tick(); tick();
    chk("t2_done_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", got[i], 4'(i));

    // non-matching finish id is ignored
    push(4'd2, 16'd9);
    wait_run();
    n = got.size();
    core_finished = 1'b1; core_finished_warp_id = 4'd5;
    repeat (3) tick();
    core_finished = 1'b0;
    tick();
    chk("t3_no_retire", got.size(), n);
    finish(4'd2);
    tick(); tick();
    chk("t3_retire", got.size(), n + 1);
    chk("t3_retire_id", got[$], 4'd2);

    // zero-thread kernel
    low_cnt = 0;
    push(4'd7, 16'd0);
    push_cyc = cyc;
    repeat (5) tick();
    chk("t4_core_never_released", low_cnt, 0);
    chk("t4_done_id", got[$], 4'd7);
    chk("t4_done_latency", done_cyc - push_cyc, 2);

    // flush while warp 1 runs
    push(4'd1, 16'd5);
    wait_run();
    push(4'd8, 16'd3); push(4'd9, 16'd3); push(4'd10, 16'd3);
    chk("t5_queued", queue_count, 3'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_flushed", queue_count, 3'd0);
    finish(4'd1);
    tick();
    chk("t5_retire_id", got[$], 4'd1);
    low_cnt = 0;
    repeat (10) tick();
    chk("t5_no_launch", low_cnt, 0);
    chk("t5_idle", busy, 1'b0);
    submit_valid = 1'b1; flush = 1'b1; tick(); submit_valid = 1'b0; flush = 1'b0;
    chk("t5_flush_wins", queue_count, 3'd0);

    // reset mid-RUN
    push(4'd4, 16'd3);
    wait_run();
    n = got.size();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_core_rst", core_rst, 1'b1);
    chk("t6_done_valid", done_valid, 1'b0);
    chk("t6_retired", warps_retired, 16'd0);
    chk("t6_kernel", core_kernel, 52'd0);
    tick(); tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("t6_no_pulse", got.size(), n);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      submit_valid = 1'($urandom_range(0, 1));
      submit_kernel.warp_id = 4'($urandom);
      submit_kernel.start_pc = $urandom;
      submit_kernel.thread_count = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      flush = ($urandom_range(0, 49) == 0);
      core_finished = ($urandom_range(0, 3) == 0);
      core_finished_warp_id = $urandom_range(0, 1) ? m_act.warp_id : 4'($urandom);
      tick();
    end
    submit_valid = 1'b0; flush = 1'b0; core_finished = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
